note_seq_ctrl: RTL and testbench



---
 rtl/note_seq_ctrl_if.sv | 26 ++
 rtl/note_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_note_seq_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/note_seq_ctrl_if.sv
// Pattern write bus into the note sequencer.
// One entry is written per cycle while wr_en is high.
// There is no back-pressure: the sequencer accepts every write in any state.
// The entry layout is {oct, note}; note 12..15 encodes a rest.
interface note_seq_ctrl_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_note;
    logic [1:0] wr_oct;

    // The board-side loader drives the bus.
    modport master (
        output wr_en,
        output wr_addr,
        output wr_note,
        output wr_oct
    );

    // The sequencer only observes the bus.
    modport slave (
        input wr_en,
        input wr_addr,
        input wr_note,
        input wr_oct
    );
endinterface

// File: rtl/note_seq_ctrl.sv
// Step sequencer feeding the audio clock divider.
// It steps through an 8-entry note pattern, advancing one step every TEMPO_DIV cycles.
// During the last GAP_CYCLES cycles of each step it mutes the output.
// Outputs change only when a step is loaded. A pattern write to the step that is
// playing is therefore heard the next time that step comes round.
module note_seq_ctrl #(
    parameter int TEMPO_DIV  = 12500000,
    parameter int GAP_CYCLES = 1250000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 play,
    note_seq_ctrl_if.slave       wr,
    input  logic [3:0]           len,
    output logic [10:0]          sw_out,
    output logic [1:0]           octave_out,
    output logic                 mute,
    output logic [2:0]           step_idx,
    output logic                 step_pulse,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    localparam int CNT_W = (TEMPO_DIV > 1) ? $clog2(TEMPO_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TEMPO_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(TEMPO_DIV - GAP_CYCLES - 1);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Each pattern entry is {oct[1:0], note[3:0]}.
    logic [5:0] pat [8];

    logic [3:0]  eff_len;
    logic [2:0]  nxt_idx;
    logic [2:0]  ld_idx;
    logic [3:0]  ld_note;
    logic [1:0]  ld_oct;
    logic        ld_rest;
    logic [10:0] ld_sw;
    logic        at_boundary;
    logic        do_load;

    assign state_dbg = state;

    // Pattern RAM: written from the bus in any state. Reset fills it with rests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                pat[i] <= 6'b00_1111;
            end
        end else if (wr.wr_en) begin
            pat[wr.wr_addr] <= {wr.wr_oct, wr.wr_note};
        end
    end

    // Pick the next step and decode its pattern entry into divider controls.
    always_comb begin
        eff_len = ((len == 4'd0) || (len > 4'd8)) ? 4'd8 : len;
        // A step index at or beyond the new loop end wraps to 0.
        nxt_idx = ({1'b0, step_idx} >= (eff_len - 4'd1)) ? 3'd0 : (step_idx + 3'd1);
        ld_idx  = (state == IDLE) ? 3'd0 : nxt_idx;
        ld_note = pat[ld_idx][3:0];
        ld_oct  = pat[ld_idx][5:4];
        ld_rest = (ld_note >= 4'd12);
        // Note 0 is the root: no half-step is selected.
        // Note n in 1..11 selects bit (11-n).
        if (ld_note == 4'd0 || ld_rest) begin
            ld_sw = 11'd0;
        end else begin
            ld_sw = 11'h400 >> (ld_note - 4'd1);
        end
        at_boundary = (cnt == CNT_LAST);
        do_load     = play && ((state == IDLE) || at_boundary);
    end

    // Sequencer FSM. A stop beats a step boundary in the same cycle.
    // All outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            step_idx   <= 3'd0;
            sw_out     <= 11'd0;
            octave_out <= 2'd0;
            mute       <= 1'b1;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if ((state != IDLE) && !play) begin
                // Stop: the divider controls keep their last values under mute.
                state    <= IDLE;
                cnt      <= '0;
                step_idx <= 3'd0;
                mute     <= 1'b1;
                busy     <= 1'b0;
            end else if (do_load) begin
                // Start from IDLE or cross a step boundary.
                // A rest mutes the step and leaves the divider controls untouched.
                state      <= NOTE;
                cnt        <= '0;
                step_idx   <= ld_idx;
                step_pulse <= 1'b1;
                busy       <= 1'b1;
                mute       <= ld_rest;
                if (!ld_rest) begin
                    sw_out     <= ld_sw;
                    octave_out <= ld_oct;
                end
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
                if ((state == NOTE) && HAS_GAP && (cnt == CNT_GAP)) begin
                    state <= GAP;
                    mute  <= 1'b1;
                end
            end else begin
                mute <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Bench for note_seq_ctrl with TEMPO_DIV=10 and GAP_CYCLES=2.
// A second instance with GAP_CYCLES=0 runs alongside it on the same inputs.
module tb_note_seq_ctrl;
    localparam int TD = 10;
    localparam int GP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic play = 1'b0;
    logic [3:0] len = 4'd0;

    always #5 clk = ~clk;

    note_seq_ctrl_if wr_bus ();

    logic [10:0] sw_out;
    logic [1:0]  octave_out;
    logic        mute;
    logic [2:0]  step_idx;
    logic        step_pulse;
    logic        busy;
    logic [1:0]  state_dbg;

    logic [10:0] sw_l;
    logic [1:0]  oct_l;
    logic        mute_l;
    logic [2:0]  idx_l;
    logic        pulse_l;
    logic        busy_l;
    logic [1:0]  state_l;

    note_seq_ctrl #(.TEMPO_DIV(TD), .GAP_CYCLES(GP)) dut (
        .clk(clk), .rst(rst), .play(play), .wr(wr_bus.slave), .len(len),
        .sw_out(sw_out), .octave_out(octave_out), .mute(mute), .step_idx(step_idx),
        .step_pulse(step_pulse), .busy(busy), .state_dbg(state_dbg)
    );

    note_seq_ctrl #(.TEMPO_DIV(TD), .GAP_CYCLES(0)) dut_legato (
        .clk(clk), .rst(rst), .play(play), .wr(wr_bus.slave), .len(len),
        .sw_out(sw_l), .octave_out(oct_l), .mute(mute_l), .step_idx(idx_l),
        .step_pulse(pulse_l), .busy(busy_l), .state_dbg(state_l)
    );

    int checks = 0;
    int failures = 0;

    // Each expected step is packed as {idx[2:0], sw[10:0], oct[1:0], mute_in_note}.
    logic [16:0] exp_q[$];

    function automatic logic [16:0] mk(input logic [2:0] idx, input logic [10:0] sw,
                                       input logic [1:0] oct, input logic m);
        return {idx, sw, oct, m};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: write one pattern entry.
    task automatic write_entry(input logic [2:0] addr, input logic [3:0] note, input logic [1:0] oct);
        @(negedge clk);
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_addr = addr;
        wr_bus.wr_note = note;
        wr_bus.wr_oct  = oct;
        @(negedge clk);
        wr_bus.wr_en   = 1'b0;
    endtask

    // Driver: wait for n step pulses within a bounded budget.
    // Returns at the negedge of the last pulse, which is cycle 0 of that step.
    task automatic wait_pulses(input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 40 * TD) begin
            @(negedge clk);
            cyc++;
            if (step_pulse) seen++;
        end
        check("pulse_wait", seen, n);
    endtask

    // Monitor: pop and compare on every step pulse, and check mute and period every cycle.
    int   since = -1;
    logic cur_mute = 1'b1;
    logic exp_mute;
    logic [16:0] e;
    always @(negedge clk) begin
        if (rst || !busy) since = -1;
        else if (since >= 0) since++;
        if (step_pulse) begin
            if (since >= 0) check("period", since, TD);
            since = 0;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got step_idx %0d expected no pulse at %0t", step_idx, $time);
            end else begin
                e = exp_q.pop_front();
                check("step_idx", step_idx, e[16:14]);
                check("sw_out", sw_out, e[13:3]);
                check("octave_out", octave_out, e[2:1]);
                cur_mute = e[0];
            end
        end
        exp_mute = (!busy) ? 1'b1 : ((since < TD - GP) ? cur_mute : 1'b1);
        check("mute", mute, exp_mute);
        if (busy) begin
            check("legato_mute", mute_l, cur_mute);
            check("legato_pulse", pulse_l, step_pulse);
            check("legato_idx", idx_l, step_idx);
            check("legato_sw", sw_l, sw_out);
            check("legato_oct", oct_l, octave_out);
            check("legato_no_gap", state_l == 2'd2, 1'b0);
        end
        check("legato_busy", busy_l, busy);
    end

    initial begin
        wr_bus.wr_en   = 1'b0;
        wr_bus.wr_addr = 3'd0;
        wr_bus.wr_note = 4'd0;
        wr_bus.wr_oct  = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_sw", sw_out, 11'd0);
        check("rst_oct", octave_out, 2'd0);
        check("rst_mute", mute, 1'b1);
        check("rst_idx", step_idx, 3'd0);
        check("rst_pulse", step_pulse, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        rst = 1'b0;

        // Cleared pattern with len 0 (treated as 8): eight rests, then wrap.
        for (int i = 0; i < 10; i++) exp_q.push_back(mk(3'(i % 8), 11'd0, 2'd0, 1'b1));
        @(negedge clk);
        play = 1'b1;
        wait_pulses(10);
        play = 1'b0;
        repeat (2) @(negedge clk);
        check("stop1_busy", busy, 1'b0);

        // Notes 0,1,7,11 with octave codes 00,10,01,00 and len 4.
        write_entry(3'd0, 4'd0, 2'b00);
        write_entry(3'd1, 4'd1, 2'b10);
        write_entry(3'd2, 4'd7, 2'b01);
        write_entry(3'd3, 4'd11, 2'b00);
        len = 4'd4;
        for (int i = 0; i < 11; i++) begin
            case (i % 4)
                0: exp_q.push_back(mk(3'd0, 11'h000, 2'b00, 1'b0));
                1: exp_q.push_back(mk(3'd1, 11'h400, 2'b10, 1'b0));
                2: exp_q.push_back(mk(3'd2, 11'h010, 2'b01, 1'b0));
                default: exp_q.push_back(mk(3'd3, 11'h001, 2'b00, 1'b0));
            endcase
        end
        @(negedge clk);
        play = 1'b1;
        wait_pulses(11);

        // Drop play at cycle 5 of step 2.
        repeat (5) @(negedge clk);
        play = 1'b0;
        @(negedge clk);
        check("stop_busy", busy, 1'b0);
        check("stop_mute", mute, 1'b1);
        check("stop_idx", step_idx, 3'd0);
        check("stop_state", state_dbg, 2'd0);
        check("stop_sw_hold", sw_out, 11'h010);
        check("stop_oct_hold", octave_out, 2'b01);
        check("stop_no_pulse", step_pulse, 1'b0);

        // Restart from step 0, then play on to step 3.
        exp_q.push_back(mk(3'd0, 11'h000, 2'b00, 1'b0));
        exp_q.push_back(mk(3'd1, 11'h400, 2'b10, 1'b0));
        exp_q.push_back(mk(3'd2, 11'h010, 2'b01, 1'b0));
        exp_q.push_back(mk(3'd3, 11'h001, 2'b00, 1'b0));
        play = 1'b1;
        wait_pulses(4);

        // While step 3 plays, rewrite entry 3 to note 5 and shrink len to 2.
        len = 4'd2;
        write_entry(3'd3, 4'd5, 2'b00);
        exp_q.push_back(mk(3'd0, 11'h000, 2'b00, 1'b0));
        exp_q.push_back(mk(3'd1, 11'h400, 2'b10, 1'b0));
        exp_q.push_back(mk(3'd0, 11'h000, 2'b00, 1'b0));
        @(negedge clk);
        check("hold_current_sw", sw_out, 11'h001);
        check("hold_current_idx", step_idx, 3'd3);
        wait_pulses(3);
        len = 4'd4;
        exp_q.push_back(mk(3'd1, 11'h400, 2'b10, 1'b0));
        exp_q.push_back(mk(3'd2, 11'h010, 2'b01, 1'b0));
        exp_q.push_back(mk(3'd3, 11'h040, 2'b00, 1'b0));
        wait_pulses(3);

        // Reset mid-step: outputs return at once and the pattern is cleared.
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_mute", mute, 1'b1);
        check("arst_sw", sw_out, 11'd0);
        check("arst_oct", octave_out, 2'd0);
        check("arst_idx", step_idx, 3'd0);
        exp_q.push_back(mk(3'd0, 11'd0, 2'd0, 1'b1));
        exp_q.push_back(mk(3'd1, 11'd0, 2'd0, 1'b1));
        @(negedge clk);
        rst = 1'b0;
        wait_pulses(2);
        play = 1'b0;
        repeat (3) @(negedge clk);
        check("end_busy", busy, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
